// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave
//  Purpose  : SPI mode-0 (MSB first) slave. SCLK/CS/MOSI are resynchronised
//             into CTRL_CLK. Received frames go into an RX FIFO. Transmit
//             data comes from a single-entry TX shadow register.
//  Revision : 1.0  initial release
// ============================================================================
module spi_slave #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CTRL_CLK,
  input  logic                          NRST,
  input  logic                          ENABLE,
  input  logic                          SCLK,
  input  logic                          CS,
  input  logic                          MOSI,
  output logic                          MISO,
  input  logic [DATA_W-1:0]             TX_data,
  input  logic                          TX_load,
  output logic                          TX_ready,
  output logic [DATA_W-1:0]             RX_data,
  input  logic                          RX_pop,
  output logic                          RX_empty,
  output logic [$clog2(FIFO_DEPTH):0]   RX_count,
  output logic                          RX_ovf
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_BW = $clog2(DATA_W + 1);
  localparam logic [c_BW-1:0] c_LAST = c_BW'(DATA_W - 1);
  localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_LOAD  = 2'd1;
  localparam logic [1:0] c_SHIFT = 2'd2;

  // synchronizer stages
  logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic r_cs_s1, r_cs_s2, r_cs_s3;
  logic r_mosi_s1, r_mosi_s2;
  logic [1:0] r_settle;

  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

  // FSM
  logic [1:0] r_state, w_state_nxt;
  logic w_load, w_shift_active, w_sample, w_drive, w_push, w_reload, w_consume;

  // datapath
  logic [DATA_W-1:0] r_tx_shift;
  logic [DATA_W-2:0] r_rx_shift;      // the final bit is taken straight from MOSI
  logic [c_BW-1:0]   r_bit_cnt;
  logic              r_reload_pend;
  logic [DATA_W-1:0] w_rx_byte;

  // TX shadow
  logic [DATA_W-1:0] r_tx_shadow;
  logic              r_tx_full;

  // RX FIFO
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]   r_wptr, r_rptr;
  logic [c_AW:0]     r_count;
  logic              r_ovf;
  logic              w_pop, w_full, w_wr;

  // Three-stage capture of the asynchronous SPI pins. r_settle masks the
  // CS falling edge until the chain has refilled from the pin after reset,
  // so CS held low across reset cannot start a frame.
  always_ff @(posedge CTRL_CLK) begin
    if (!NRST) begin
      r_sclk_s1 <= 1'b0; r_sclk_s2 <= 1'b0; r_sclk_s3 <= 1'b0;
      r_cs_s1   <= 1'b1; r_cs_s2   <= 1'b1; r_cs_s3   <= 1'b1;
      r_mosi_s1 <= 1'b0; r_mosi_s2 <= 1'b0;
      r_settle  <= 2'd0;
    end else begin
      r_sclk_s1 <= SCLK;  r_sclk_s2 <= r_sclk_s1; r_sclk_s3 <= r_sclk_s2;
      r_cs_s1   <= CS;    r_cs_s2   <= r_cs_s1;   r_cs_s3   <= r_cs_s2;
      r_mosi_s1 <= MOSI;  r_mosi_s2 <= r_mosi_s1;
      if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
    end
  end

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_s3;
  assign w_cs_fall   = ~r_cs_s2 & r_cs_s3 & (r_settle == 2'd3);
  assign w_cs_rise   = r_cs_s2 & ~r_cs_s3;
  assign w_rx_byte   = {r_rx_shift, r_mosi_s2};

  // FSM state register
  always_ff @(posedge CTRL_CLK) begin
    if (!NRST) r_state <= c_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (ENABLE && w_cs_fall) w_state_nxt = c_LOAD;
      c_LOAD:  w_state_nxt = (!ENABLE || w_cs_rise) ? c_IDLE : c_SHIFT;
      c_SHIFT: if (!ENABLE || w_cs_rise) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // FSM outputs: datapath strobes and the MISO pin
  always_comb begin
    w_load         = (r_state == c_LOAD) && (w_state_nxt == c_SHIFT);
    w_shift_active = (r_state == c_SHIFT) && (w_state_nxt == c_SHIFT);
    w_sample       = w_shift_active && w_sclk_rise;
    w_drive        = w_shift_active && w_sclk_fall;
    w_push         = w_sample && (r_bit_cnt == c_LAST);
    w_reload       = w_drive && r_reload_pend;
    w_consume      = w_load || w_reload;
    MISO           = (r_state == c_SHIFT) ? r_tx_shift[DATA_W-1] : 1'b0;
  end

  // Shift registers and bit counter
  always_ff @(posedge CTRL_CLK) begin
    if (!NRST) begin
      r_tx_shift    <= '0;
      r_rx_shift    <= '0;
      r_bit_cnt     <= '0;
      r_reload_pend <= 1'b0;
    end else begin
      if (w_consume)    r_tx_shift <= r_tx_full ? r_tx_shadow : '0;
      else if (w_drive) r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};

      if (w_load) begin
        r_bit_cnt     <= '0;
        r_reload_pend <= 1'b0;
      end else if (w_sample) begin
        r_rx_shift <= w_rx_byte[DATA_W-2:0];
        if (w_push) begin
          r_bit_cnt     <= '0;
          r_reload_pend <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + c_BW'(1);
        end
      end else if (w_reload) begin
        r_reload_pend <= 1'b0;
      end

      // leaving the frame discards any partial byte
      if ((r_state != c_IDLE) && (w_state_nxt == c_IDLE)) begin
        r_bit_cnt     <= '0;
        r_reload_pend <= 1'b0;
      end
    end
  end

  // TX shadow register: consumption takes effect before a same-cycle load
  always_ff @(posedge CTRL_CLK) begin
    if (!NRST) begin
      r_tx_shadow <= '0;
      r_tx_full   <= 1'b0;
    end else begin
      if (w_consume) r_tx_full <= 1'b0;
      if (TX_load && (!r_tx_full || w_consume)) begin
        r_tx_shadow <= TX_data;
        r_tx_full   <= 1'b1;
      end
    end
  end

  assign w_pop  = RX_pop && (r_count != '0);
  assign w_full = (r_count == c_FULL);
  assign w_wr   = w_push && (!w_full || w_pop);

  // FIFO storage (no reset needed; occupancy tracks validity)
  always_ff @(posedge CTRL_CLK) begin
    if (w_wr) r_mem[r_wptr] <= w_rx_byte;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge CTRL_CLK) begin
    if (!NRST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + c_AW'(1);
      if (w_pop) r_rptr <= r_rptr + c_AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (c_AW + 1)'(1);
        2'b01:   r_count <= r_count - (c_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (!ENABLE)                        r_ovf <= 1'b0;
      else if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  assign TX_ready = ~r_tx_full;
  assign RX_data  = r_mem[r_rptr];
  assign RX_empty = (r_count == '0);
  assign RX_count = r_count;
  assign RX_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave
//  Purpose  : Self-checking bench for spi_slave: directed scenarios plus
//             randomized frames against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_slave;

  localparam int HALF = 4;   // SCLK half period in CTRL_CLK cycles

  logic       CTRL_CLK = 1'b0;
  logic       NRST = 1'b0, ENABLE = 1'b1;
  logic       SCLK = 1'b0, CS = 1'b1, MOSI = 1'b0;
  logic       MISO;
  logic [7:0] TX_data = 8'h00;
  logic       TX_load = 1'b0, TX_ready;
  logic [7:0] RX_data;
  logic       RX_pop = 1'b0, RX_empty;
  logic [2:0] RX_count;
  logic       RX_ovf;

  spi_slave #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
    .CTRL_CLK(CTRL_CLK), .NRST(NRST), .ENABLE(ENABLE),
    .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
    .TX_data(TX_data), .TX_load(TX_load), .TX_ready(TX_ready),
    .RX_data(RX_data), .RX_pop(RX_pop), .RX_empty(RX_empty),
    .RX_count(RX_count), .RX_ovf(RX_ovf)
  );

  always #5 CTRL_CLK = ~CTRL_CLK;

  // reference model state
  logic [7:0] q[$];
  logic       m_full = 1'b0;
  logic [7:0] m_shadow = 8'h00;
  logic       m_ovf = 1'b0;
  logic [7:0] m_cur = 8'h00;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic take(output logic [7:0] v);
    if (m_full) begin v = m_shadow; m_full = 1'b0; end
    else v = 8'h00;
  endtask

  task automatic model_push(input logic [7:0] b, input bit pop_same);
    if (pop_same && q.size() > 0) void'(q.pop_front());
    if (q.size() < 4) q.push_back(b);
    else m_ovf = 1'b1;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, RX_count, q.size());
    check({tag, "_empty"}, RX_empty, q.size() == 0);
    check({tag, "_ovf"},   RX_ovf, m_ovf);
    check({tag, "_txrdy"}, TX_ready, !m_full);
    check({tag, "_miso"},  MISO, 1'b0);
    if (q.size() > 0) check({tag, "_head"}, RX_data, q[0]);
  endtask

  task automatic tx_load(input logic [7:0] d);
    @(negedge CTRL_CLK); TX_data = d; TX_load = 1'b1;
    @(negedge CTRL_CLK); TX_load = 1'b0;
    if (!m_full) begin m_shadow = d; m_full = 1'b1; end
  endtask

  task automatic pop();
    @(negedge CTRL_CLK);
    if (q.size() > 0) check("pop_head", RX_data, q[0]);
    RX_pop = 1'b1;
    @(negedge CTRL_CLK); RX_pop = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic start_frame();
    @(negedge CTRL_CLK); CS = 1'b0;
    repeat (6) @(negedge CTRL_CLK);
    take(m_cur);
  endtask

  task automatic end_frame();
    repeat (HALF) @(negedge CTRL_CLK);
    CS = 1'b1;
    repeat (6) @(negedge CTRL_CLK);
  endtask

  // Clocks nbits of b; checks each MISO bit the master samples. With
  // pop_last, RX_pop is pulsed in the cycle the final bit is captured.
  task automatic send_byte(input logic [7:0] b, input int nbits, input bit pop_last);
    for (int i = 0; i < nbits; i++) begin
      @(negedge CTRL_CLK); MOSI = b[7-i];
      repeat (HALF) @(negedge CTRL_CLK);
      SCLK = 1'b1;
      check("miso_bit", MISO, m_cur[7-i]);
      if (pop_last && i == nbits - 1) begin
        repeat (2) @(negedge CTRL_CLK);
        RX_pop = 1'b1;
        @(negedge CTRL_CLK); RX_pop = 1'b0;
        repeat (HALF - 3) @(negedge CTRL_CLK);
      end else begin
        repeat (HALF) @(negedge CTRL_CLK);
      end
      SCLK = 1'b0;
    end
    if (nbits == 8) begin
      model_push(b, pop_last);
      take(m_cur);
    end
  endtask

  // SCLK toggling with no model effect (slave expected to ignore it)
  task automatic raw_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      @(negedge CTRL_CLK); MOSI = b[7-i];
      repeat (HALF) @(negedge CTRL_CLK); SCLK = 1'b1;
      check("raw_miso", MISO, 1'b0);
      repeat (HALF) @(negedge CTRL_CLK); SCLK = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int n;

    // reset values
    repeat (3) @(negedge CTRL_CLK);
    check_status("reset");
    NRST = 1'b1;
    repeat (2) @(negedge CTRL_CLK);

    // TX 0xA5 while receiving 0x3C
    tx_load(8'hA5);
    check("txrdy_loaded", TX_ready, 1'b0);
    start_frame();
    send_byte(8'h3C, 8, 1'b0);
    end_frame();
    check_status("a5_3c");
    check("a5_3c_data", RX_data, 8'h3C);

    // two bytes, no TX data: MISO zero, order kept
    pop();
    start_frame();
    send_byte(8'h11, 8, 1'b0);
    send_byte(8'h22, 8, 1'b0);
    end_frame();
    check_status("two_bytes");
    pop();
    check("second_head", RX_data, 8'h22);
    pop();
    check_status("drained");

    // overflow with five bytes, ENABLE low clears flag only
    start_frame();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 8, 1'b0);
    end_frame();
    check_status("ovf");
    check("ovf_set", RX_ovf, 1'b1);
    @(negedge CTRL_CLK); ENABLE = 1'b0;
    repeat (2) @(negedge CTRL_CLK); ENABLE = 1'b1;
    m_ovf = 1'b0;
    @(negedge CTRL_CLK);
    check_status("en_low");

    // push and pop in the same cycle while full
    start_frame();
    send_byte(8'h77, 8, 1'b1);
    end_frame();
    check_status("push_pop_full");
    check("ppf_count", RX_count, 3'd4);

    // partial frame discarded, next frame intact
    repeat (4) pop();
    start_frame();
    send_byte(8'hF0, 5, 1'b0);
    end_frame();
    check_status("partial");
    start_frame();
    send_byte(8'h81, 8, 1'b0);
    end_frame();
    check_status("after_partial");
    check("data_81", RX_data, 8'h81);
    pop();

    // TX_load while shadow full is ignored
    tx_load(8'h5A);
    tx_load(8'hFF);
    check("txrdy_full", TX_ready, 1'b0);
    start_frame();
    send_byte(8'hC3, 8, 1'b0);
    end_frame();
    check_status("tx_ignore");

    // randomized frames
    for (int k = 0; k < 10; k++) begin
      n = $urandom_range(0, 2);
      for (int p = 0; p < n; p++) pop();
      if ($urandom_range(0, 1) == 1) tx_load(8'($urandom));
      start_frame();
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) send_byte(8'($urandom), 8, 1'b0);
      end_frame();
      check_status("rand");
    end

    // reset mid-frame; CS still low afterwards must not start a frame
    tx_load(8'h3E);
    start_frame();
    send_byte(8'h9D, 3, 1'b0);
    @(negedge CTRL_CLK); NRST = 1'b0;
    @(negedge CTRL_CLK);
    check("rst_miso",  MISO, 1'b0);
    check("rst_txrdy", TX_ready, 1'b1);
    check("rst_empty", RX_empty, 1'b1);
    check("rst_count", RX_count, 3'd0);
    check("rst_ovf",   RX_ovf, 1'b0);
    NRST = 1'b1;
    q.delete(); m_full = 1'b0; m_ovf = 1'b0;
    SCLK = 1'b0;
    repeat (2) @(negedge CTRL_CLK);
    raw_byte(8'hB7);
    repeat (HALF) @(negedge CTRL_CLK);
    check_status("cs_held");
    CS = 1'b1;
    repeat (6) @(negedge CTRL_CLK);
    b = 8'($urandom);
    start_frame();
    send_byte(b, 8, 1'b0);
    end_frame();
    check_status("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter DATA_W, default 8, bits per SPI frame.
REQ-002 Parameter FIFO_DEPTH, default 4, RX FIFO entries (power of two, >=2).
REQ-003 CTRL_CLK  input  1  system clock; all logic on its rising edge.
REQ-004 NRST  input  1  reset, synchronous, active-low.
REQ-005 ENABLE  input  1  block enable; low forces IDLE.
REQ-006 SCLK  input  1  SPI clock from master, asynchronous to CTRL_CLK.
REQ-007 CS  input  1  chip select from master, active-low, asynchronous.
REQ-008 MOSI  input  1  serial data from master, asynchronous.
REQ-009 MISO  output  1  serial data to master.
REQ-010 TX_data  input  DATA_W  next byte to transmit.
REQ-011 TX_load  input  1  one-cycle strobe; writes TX_data into TX shadow register.
REQ-012 TX_ready  output  1  high when TX shadow register is empty.
REQ-013 RX_data  output  DATA_W  FIFO head byte; valid while RX_empty low.
REQ-014 RX_pop  input  1  one-cycle strobe; removes FIFO head.
REQ-015 RX_empty  output  1  FIFO empty flag.
REQ-016 RX_count  output  clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-017 RX_ovf  output  1  sticky overflow flag.

Function
REQ-018 SCLK, CS, MOSI each pass through a 2-flop synchronizer; edges detected by comparing stage 2 with a third registered stage.
REQ-019 SPI mode 0, MSB first: MOSI sampled on detected SCLK rising edge; MISO updated on detected SCLK falling edge.
REQ-020 Latency: pin edge to internal edge-detect pulse is exactly 3 CTRL_CLK cycles; SCLK high and low phases each >= 2 CTRL_CLK periods are supported.
REQ-021 FSM states: IDLE, LOAD, SHIFT.
REQ-022 IDLE -> LOAD on synchronized CS falling edge while ENABLE high; any other condition stays in IDLE.
REQ-023 LOAD (one cycle): TX shift register <= shadow if TX_ready low (shadow then marked empty), else all zeros; MISO <= MSB of loaded value; bit counter <= 0; -> SHIFT.
REQ-024 SHIFT: each rising edge shifts MOSI into RX shift register LSB and increments bit counter; each falling edge shifts TX register left, MISO <= new MSB.
REQ-025 On the DATA_W-th rising edge: assembled byte pushed to FIFO in the same cycle as the last bit is sampled; bit counter -> 0; TX register reloaded per REQ-023 rule on the following falling edge, MISO <= its MSB.
REQ-026 SHIFT -> IDLE on synchronized CS rising edge or ENABLE low; partial byte discarded, no push, bit counter -> 0.
REQ-027 In IDLE, MISO = 0.
REQ-028 TX_load while TX_ready low is ignored; TX_load in the same cycle the shadow is consumed: consume first, new data accepted, TX_ready stays low.
REQ-029 FIFO push while full (RX_count == FIFO_DEPTH) and no pop: byte dropped, RX_ovf <= 1.
REQ-030 Simultaneous push and pop when full: both performed, RX_count unchanged, no overflow.
REQ-031 RX_pop while empty ignored; RX_count never underflows.
REQ-032 Pointers wrap modulo FIFO_DEPTH; RX_data is combinational from head entry.
REQ-033 RX_ovf cleared only by reset or ENABLE low.
REQ-034 ENABLE low retains FIFO contents and TX shadow.

Reset
REQ-035 NRST low at a CTRL_CLK edge: FSM -> IDLE, MISO = 0, TX_ready = 1, RX_empty = 1, RX_count = 0, RX_ovf = 0, shift registers, bit counter, pointers = 0, synchronizer flops = idle levels (SCLK 0, CS 1, MOSI 0).
REQ-036 Reset mid-frame aborts the frame; no byte pushed; next frame requires a fresh CS falling edge.

Verification
REQ-037 TX_load 0xA5, CS low, master clocks 0x3C -> MISO bits 1,0,1,0,0,1,0,1; RX_data = 0x3C, RX_count = 1, TX_ready = 1.
REQ-038 CS low, 2 bytes 0x11, 0x22 with no TX_load -> MISO all 0; FIFO holds 0x11 then 0x22 in order.
REQ-039 5 bytes with FIFO_DEPTH 4, no pops -> RX_count = 4, RX_ovf = 1, entries bytes 1-4; ENABLE low clears RX_ovf, entries kept.
REQ-040 CS raised after 5 bits -> no push, RX_count unchanged; next full frame 0x81 received correctly.
REQ-041 RX_pop asserted in same cycle as 8th-bit push with FIFO full -> RX_count stays 4, RX_ovf = 0.
REQ-042 NRST low after 3 bits -> all outputs at REQ-035 values one cycle later; RX_empty = 1.
